// File: rtl/bfm_apb_pkg.sv
// Shared APB BFM definitions: FSM encoding, bus width, slot-decode field and
// the slave address-error check.
package bfm_apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int APB_DW  = 32;
  localparam int SLOT_HI = 27;
  localparam int SLOT_LO = 24;
  localparam int DEC_AW  = 24;  // byte-address bits a slave decodes

  // Misaligned, or any decoded bit above the word index of a 2^aw-word memory.
  function automatic logic addr_err(input logic [DEC_AW-1:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/bfm_apbslave_mem_if.sv
// APB3 completer-side bus bundle: one PSEL slot plus the shared bridge bus.
interface bfm_apbslave_mem_if;
  import bfm_apb_pkg::*;

  logic              psel;
  logic [31:0]       paddr;
  logic              pwrite;
  logic              penable;
  logic [APB_DW-1:0] pwdata;
  logic [APB_DW-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, paddr, pwrite, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, paddr, pwrite, penable, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/bfm_apbslave_ram.sv
// Word storage for the APB slave memory: synchronous write, combinational read,
// cleared on reset.
module bfm_apbslave_ram
  import bfm_apb_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [APB_DW-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [APB_DW-1:0] rdata
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [APB_DW-1:0] mem_q [DEPTH];

  // NOTE: the array is reset because the model must read back zero after any
  // reset; this forces flops rather than a RAM macro, which is fine for a BFM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bfm_apbslave_mem.sv
// APB3 slave memory model: IDLE/ACCESS FSM with programmable wait states and
// PSLVERR on misaligned or out-of-range word addresses.
module bfm_apbslave_mem
  import bfm_apb_pkg::*;
#(
  parameter int AWIDTH      = 8,
  parameter int WAIT_STATES = 2
) (
  input logic               PCLK,
  input logic               PRESETN,
  bfm_apbslave_mem_if.slave apb
);

  state_e            state_q, state_d;
  logic [DEC_AW-1:0] addr_q, addr_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;

  logic              ram_we;
  logic [APB_DW-1:0] ram_rdata;
  logic [DEC_AW-1:0] resp_addr;
  logic              resp_write;
  logic              resp_err;
  logic [APB_DW-1:0] resp_rdata;

  // With zero wait states the response is built from the live setup-phase
  // bus; otherwise from the transfer latched at setup.
  assign resp_addr  = (state_q == IDLE) ? apb.paddr[DEC_AW-1:0] : addr_q;
  assign resp_write = (state_q == IDLE) ? apb.pwrite : pwrite_q;
  assign resp_err   = addr_err(resp_addr, AWIDTH);
  assign resp_rdata = (!resp_write && !resp_err) ? ram_rdata : '0;

  bfm_apbslave_ram #(
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk  (PCLK),
    .rst_n(PRESETN),
    .we   (ram_we),
    .waddr(addr_q[AWIDTH+1:2]),
    .wdata(wdata_q),
    .raddr(resp_addr[AWIDTH+1:2]),
    .rdata(ram_rdata)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pwrite_d  = pwrite_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          addr_d   = apb.paddr[DEC_AW-1:0];
          pwrite_d = apb.pwrite;
          wdata_d  = apb.pwdata;
          cnt_d    = 4'(WAIT_STATES);
          state_d  = ACCESS;
          pready_d = (WAIT_STATES == 0);
          if (WAIT_STATES == 0) begin
            pslverr_d = resp_err;
            prdata_d  = resp_rdata;
          end
        end
      end
      ACCESS: begin
        if (!apb.psel || pready_q) begin
          // Abort or completion: both clear the response; only a live,
          // error-free completing write reaches memory.
          ram_we    = apb.psel && pwrite_q && !resp_err;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            prdata_d  = resp_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pwrite_q  <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pwrite_q  <= pwrite_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule
